// File: rtl/ir_scan_sched_pkg.sv
// Shared types, sizes and the A2D command encoding for the IR scan scheduler.
package ir_scan_sched_pkg;

    localparam int unsigned NUM_CH   = 8;
    localparam int unsigned CH_W     = 3;
    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned CMD_W    = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CMD,
        WAIT_CMD,
        RD,
        WAIT_RD,
        DONE
    } state_e;

    // One 12-bit reading per channel, R0 in the least significant slot.
    typedef logic [NUM_CH-1:0][SAMPLE_W-1:0] ir_vec_t;

    // Second transaction of each channel pair simply clocks the result out.
    localparam logic [CMD_W-1:0] RD_CMD = '0;

    // Channel-select command word for the A2D.
    function automatic logic [CMD_W-1:0] a2d_cmd(input logic [CH_W-1:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/ir_scan_sched_timer.sv
// Scan period counter and emitter settle counter, scaled by FAST_SIM.
module ir_scan_sched_timer #(
    parameter int unsigned FAST_SIM = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic scan_en,
    input  logic settle_en,
    output logic tick_c,
    output logic settle_done_c
);

    localparam int unsigned PERIOD_W    = (FAST_SIM != 0) ? 14 : 22;
    localparam int unsigned SETTLE_CLKS = (FAST_SIM != 0) ? 256 : 4096;
    localparam int unsigned SETTLE_W    = 13;

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;

    // Period counter free-runs while enabled and wraps on the tick; settle counter runs only in SETTLE.
    always_comb begin
        period_d = '0;
        settle_d = '0;
        if (scan_en) begin
            period_d = period_q + PERIOD_W'(1);
        end
        if (settle_en) begin
            settle_d = settle_q + SETTLE_W'(1);
        end
    end

    assign tick_c        = scan_en && (period_q == {PERIOD_W{1'b1}});
    assign settle_done_c = settle_en && (settle_q == SETTLE_W'(SETTLE_CLKS - 1));

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= '0;
            settle_q <= '0;
        end else begin
            period_q <= period_d;
            settle_q <= settle_d;
        end
    end

endmodule

// File: rtl/ir_scan_sched.sv
// Periodic IR scan: power emitters, settle, read 8 channels over SPI, publish atomically.
module ir_scan_sched
    import ir_scan_sched_pkg::*;
#(
    parameter int unsigned           FAST_SIM   = 1,
    parameter logic [SAMPLE_W-1:0]   LINE_THRES = 12'hA00
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       scan_en,
    output logic                       wrt_SPI,
    output logic [CMD_W-1:0]           spi_cmd,
    input  logic                       spi_done,
    input  logic [CMD_W-1:0]           spi_rd,
    output logic                       IR_en,
    output logic [NUM_CH*SAMPLE_W-1:0] ir_data,
    output logic                       IR_vld,
    output logic                       line_present,
    output logic                       ovr
);

    state_e             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    ir_vec_t            shadow_q, shadow_d;
    ir_vec_t            ir_data_q, ir_data_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic               wrt_q, wrt_d;
    logic               ir_en_q, ir_en_d;
    logic               vld_q, vld_d;
    logic               line_q, line_d;
    logic               ovr_q, ovr_d;

    logic               tick_c;
    logic               settle_done_c;
    logic               settle_en_c;
    logic               line_over_c;
    logic               spi_rd_unused_c;

    assign settle_en_c     = (state_q == SETTLE);
    assign spi_rd_unused_c = ^spi_rd[CMD_W-1:SAMPLE_W];

    ir_scan_sched_timer #(
        .FAST_SIM (FAST_SIM)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .scan_en       (scan_en),
        .settle_en     (settle_en_c),
        .tick_c        (tick_c),
        .settle_done_c (settle_done_c)
    );

    // Any completed shadow reading at or above threshold marks a line.
    always_comb begin
        line_over_c = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (shadow_q[i] >= LINE_THRES) begin
                line_over_c = 1'b1;
            end
        end
    end

    // Scan sequencer: next state, SPI strobes, shadow capture and publish.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        shadow_d  = shadow_q;
        ir_data_d = ir_data_q;
        cmd_d     = cmd_q;
        ir_en_d   = ir_en_q;
        line_d    = line_q;
        wrt_d     = 1'b0;
        vld_d     = 1'b0;
        ovr_d     = tick_c && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (tick_c) begin
                    state_d = SETTLE;
                    ir_en_d = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_done_c) begin
                    state_d = CMD;
                    wrt_d   = 1'b1;
                    cmd_d   = a2d_cmd(ch_q);
                end
            end
            CMD: begin
                state_d = WAIT_CMD;
            end
            WAIT_CMD: begin
                if (spi_done) begin
                    state_d = RD;
                    wrt_d   = 1'b1;
                    cmd_d   = RD_CMD;
                end
            end
            RD: begin
                state_d = WAIT_RD;
            end
            WAIT_RD: begin
                if (spi_done) begin
                    shadow_d[ch_q] = spi_rd[SAMPLE_W-1:0];
                    if (ch_q == CH_W'(NUM_CH - 1)) begin
                        state_d = DONE;
                    end else begin
                        ch_d    = ch_q + CH_W'(1);
                        state_d = CMD;
                        wrt_d   = 1'b1;
                        cmd_d   = a2d_cmd(ch_q + CH_W'(1));
                    end
                end
            end
            DONE: begin
                ir_data_d = shadow_q;
                line_d    = line_over_c;
                ir_en_d   = 1'b0;
                ch_d      = '0;
                vld_d     = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any scan in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            shadow_q  <= '0;
            ir_data_q <= '0;
            cmd_q     <= '0;
            wrt_q     <= 1'b0;
            ir_en_q   <= 1'b0;
            vld_q     <= 1'b0;
            line_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            shadow_q  <= shadow_d;
            ir_data_q <= ir_data_d;
            cmd_q     <= cmd_d;
            wrt_q     <= wrt_d;
            ir_en_q   <= ir_en_d;
            vld_q     <= vld_d;
            line_q    <= line_d;
            ovr_q     <= ovr_d;
        end
    end

    assign wrt_SPI      = wrt_q;
    assign spi_cmd      = cmd_q;
    assign IR_en        = ir_en_q;
    assign ir_data      = ir_data_q;
    assign IR_vld       = vld_q;
    assign line_present = line_q;
    assign ovr          = ovr_q;

endmodule
